// File: rtl/decode_stage_hs.sv
// Decode stage: register file with writeback bypass, control/immediate decode,
// load-use stall counter and elastic valid/ready handshakes on both sides.
module decode_stage_hs #(
    parameter int              XLEN           = 32,
    parameter int              NUM_REGS       = 32,
    parameter int              LOAD_USE_STALL = 1,
    parameter logic [XLEN-1:0] RESET_PC       = {XLEN{1'b1}} << 2
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            id_valid_i,
    output logic            id_ready_o,
    input  logic [31:0]     instr_i,
    input  logic [XLEN-1:0] pc_i,
    input  logic [XLEN-1:0] btb_pc_i,
    input  logic            bp_taken_i,
    input  logic            flush_i,
    input  logic            ex_is_load_i,
    input  logic [4:0]      ex_rd_i,
    input  logic            wb_we_i,
    input  logic [4:0]      wb_rd_i,
    input  logic [XLEN-1:0] wb_data_i,
    output logic            ex_valid_o,
    input  logic            ex_ready_i,
    output logic [XLEN-1:0] rs1_data_o,
    output logic [XLEN-1:0] rs2_data_o,
    output logic [XLEN-1:0] imm_o,
    output logic [XLEN-1:0] pc_o,
    output logic [XLEN-1:0] btb_pc_o,
    output logic            bp_taken_o,
    output logic [14:0]     labels_o,
    output logic [16:0]     ctrl_o,
    output logic            stall_o
);

    localparam int CW = (LOAD_USE_STALL > 1) ? $clog2(LOAD_USE_STALL) : 1;
    localparam logic [5:0] NR = 6'(NUM_REGS);

    typedef enum logic [3:0] {
        ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
        ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND, ALU_PASSB
    } alu_op_e;

    logic [6:0] opcode;
    logic [4:0] rd, rs1, rs2;
    logic [2:0] f3;
    logic       f7b5;

    assign opcode = instr_i[6:0];
    assign rd     = instr_i[11:7];
    assign f3     = instr_i[14:12];
    assign rs1    = instr_i[19:15];
    assign rs2    = instr_i[24:20];
    assign f7b5   = instr_i[30];

    logic op_lui, op_auipc, op_jal, op_jalr, op_br, op_ld, op_st, op_imm, op_reg;

    assign op_lui   = opcode == 7'b0110111;
    assign op_auipc = opcode == 7'b0010111;
    assign op_jal   = opcode == 7'b1101111;
    assign op_jalr  = opcode == 7'b1100111;
    assign op_br    = opcode == 7'b1100011;
    assign op_ld    = opcode == 7'b0000011;
    assign op_st    = opcode == 7'b0100011;
    assign op_imm   = opcode == 7'b0010011;
    assign op_reg   = opcode == 7'b0110011;

    logic       reg_we, rs1_pc, rs2_imm, uncond;
    logic [1:0] wb_sel;
    alu_op_e    alu_op, alu_fn;

    always_comb begin
        alu_fn = ALU_ADD;
        case (f3)
            3'b000: if (op_reg && f7b5) alu_fn = ALU_SUB;
            3'b001: alu_fn = ALU_SLL;
            3'b010: alu_fn = ALU_SLT;
            3'b011: alu_fn = ALU_SLTU;
            3'b100: alu_fn = ALU_XOR;
            3'b101: alu_fn = f7b5 ? ALU_SRA : ALU_SRL;
            3'b110: alu_fn = ALU_OR;
            default: alu_fn = ALU_AND;
        endcase
    end

    // wb_sel: 0 = alu, 1 = memory, 2 = pc+4
    always_comb begin
        reg_we  = 1'b0;
        rs1_pc  = 1'b0;
        rs2_imm = 1'b0;
        uncond  = 1'b0;
        wb_sel  = 2'd0;
        alu_op  = ALU_ADD;
        unique case (1'b1)
            op_lui:   begin reg_we = 1'b1; rs2_imm = 1'b1; alu_op = ALU_PASSB; end
            op_auipc: begin reg_we = 1'b1; rs1_pc = 1'b1; rs2_imm = 1'b1; end
            op_jal:   begin
                reg_we = 1'b1; rs1_pc = 1'b1; rs2_imm = 1'b1;
                uncond = 1'b1; wb_sel = 2'd2;
            end
            op_jalr:  begin
                reg_we = 1'b1; rs2_imm = 1'b1;
                uncond = 1'b1; wb_sel = 2'd2;
            end
            op_br:    alu_op = ALU_SUB;
            op_ld:    begin reg_we = 1'b1; rs2_imm = 1'b1; wb_sel = 2'd1; end
            op_st:    rs2_imm = 1'b1;
            op_imm:   begin reg_we = 1'b1; rs2_imm = 1'b1; alu_op = alu_fn; end
            op_reg:   begin reg_we = 1'b1; alu_op = alu_fn; end
            default:  ;
        endcase
    end

    logic [31:0] imm32;

    always_comb begin
        imm32 = 32'd0;
        unique case (1'b1)
            op_lui | op_auipc: imm32 = {instr_i[31:12], 12'd0};
            op_jal:  imm32 = {{11{instr_i[31]}}, instr_i[31], instr_i[19:12],
                              instr_i[20], instr_i[30:21], 1'b0};
            op_br:   imm32 = {{19{instr_i[31]}}, instr_i[31], instr_i[7],
                              instr_i[30:25], instr_i[11:8], 1'b0};
            op_st:   imm32 = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
            op_jalr | op_ld | op_imm:
                     imm32 = {{20{instr_i[31]}}, instr_i[31:20]};
            default: imm32 = 32'd0;
        endcase
    end

    // Registers at or above NUM_REGS are never written and stay zero.
    logic [XLEN-1:0] regs [32];
    logic            wb_ok;

    assign wb_ok = wb_we_i && wb_rd_i != 5'd0 && {1'b0, wb_rd_i} < NR;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < 32; i++) regs[i] <= '0;
        end else if (wb_ok) begin
            regs[wb_rd_i] <= wb_data_i;
        end
    end

    logic [XLEN-1:0] rs1_val, rs2_val;

    assign rs1_val = (rs1 == 5'd0 || {1'b0, rs1} >= NR) ? '0 :
                     (wb_we_i && wb_rd_i == rs1) ? wb_data_i : regs[rs1];
    assign rs2_val = (rs2 == 5'd0 || {1'b0, rs2} >= NR) ? '0 :
                     (wb_we_i && wb_rd_i == rs2) ? wb_data_i : regs[rs2];

    logic          hit, store_exc, ld_st_fwd, cnt_zero, slot_free;
    logic [CW-1:0] cnt;

    assign hit = id_valid_i && ex_is_load_i && ex_rd_i != 5'd0 &&
                 (rs1 == ex_rd_i || rs2 == ex_rd_i);
    // Store data can be forwarded late from the load; only the address stalls.
    assign store_exc = op_st && rs2 == ex_rd_i && rs1 != ex_rd_i;
    assign ld_st_fwd = hit && store_exc;
    assign cnt_zero  = cnt == '0;
    assign stall_o   = !flush_i &&
                       ((hit && !store_exc && cnt_zero) || !cnt_zero);
    assign slot_free  = !ex_valid_o || ex_ready_i;
    assign id_ready_o = (slot_free && !stall_o) || flush_i;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt <= '0;
        end else if (flush_i) begin
            cnt <= '0;
        end else if (hit && !store_exc && cnt_zero) begin
            cnt <= CW'(LOAD_USE_STALL - 1);
        end else if (!cnt_zero) begin
            cnt <= cnt - CW'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ex_valid_o <= 1'b0;
            rs1_data_o <= '0;
            rs2_data_o <= '0;
            imm_o      <= '0;
            pc_o       <= RESET_PC;
            btb_pc_o   <= '0;
            bp_taken_o <= 1'b0;
            labels_o   <= '0;
            ctrl_o     <= '0;
        end else if (flush_i) begin
            ex_valid_o <= 1'b0;
        end else if (slot_free) begin
            if (stall_o) begin
                ex_valid_o <= 1'b0;
            end else if (id_valid_i) begin
                ex_valid_o <= 1'b1;
                rs1_data_o <= rs1_val;
                rs2_data_o <= rs2_val;
                imm_o      <= XLEN'($signed(imm32));
                pc_o       <= pc_i;
                btb_pc_o   <= btb_pc_i;
                bp_taken_o <= bp_taken_i;
                labels_o   <= {rd, rs1, rs2};
                ctrl_o     <= {reg_we, rs1_pc, rs2_imm, op_br, op_st, op_ld,
                               uncond, wb_sel, alu_op, f3, ld_st_fwd};
            end else begin
                ex_valid_o <= 1'b0;
            end
        end
    end

endmodule
